// File: rtl/print.sv
// print: memory-mapped console output port.
// Bytes written to TXDATA queue in a FIFO and drain one at a time.
module print #(
    parameter int FIFO_DEPTH   = 8,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        print_valid,
    input  logic        print_instr,
    input  logic [31:0] print_addr,
    input  logic [31:0] print_wdata,
    input  logic [3:0]  print_wstrb,
    output logic [31:0] print_rdata,
    output logic        print_ready
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic [DW-1:0] drain_cnt;
    logic [31:0]   txcount;

    logic [1:0]  sel;
    logic        is_write;
    logic        req;
    logic        empty;
    logic        full;
    logic        pop;
    logic        push_req;
    logic        accept;
    logic        push;
    logic        clear;
    logic        rd_status;
    logic        rd_count;
    logic [7:0]  head;
    logic [31:0] count_w;
    logic [3:0]  occ;
    logic [31:0] rd_val;
    logic        unused;

    assign unused = ^{print_addr[31:4], print_addr[1:0], print_wdata[31:8]};

    assign sel      = print_addr[3:2];
    assign is_write = |print_wstrb;
    assign req      = print_valid && !print_ready && !print_instr;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(FIFO_DEPTH);
    assign head    = mem[rptr];
    assign count_w = 32'(count);
    assign occ     = (count_w > 32'd15) ? 4'hF : count_w[3:0];

    assign pop = !empty && drain_cnt == DW'(DRAIN_CYCLES - 1);

    // A full FIFO still takes the push if the head leaves on the same edge.
    assign push_req = req && sel == 2'd0 && print_wstrb[0];
    assign accept   = print_valid && !print_ready
                   && !(push_req && full && !pop);
    assign push     = accept && push_req;
    assign clear    = accept && req && sel == 2'd2 && is_write;

    assign rd_status = !print_instr && sel == 2'd1;
    assign rd_count  = !print_instr && sel == 2'd2;

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            rd_status: rd_val = {24'd0, occ, 2'b00, full, empty};
            rd_count:  rd_val = txcount;
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            print_ready <= 1'b0;
            print_rdata <= '0;
            wptr        <= '0;
            rptr        <= '0;
            count       <= '0;
            drain_cnt   <= '0;
            txcount     <= '0;
        end else begin
            print_ready <= accept;
            print_rdata <= accept ? rd_val : '0;
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (empty || pop)
                drain_cnt <= '0;
            else
                drain_cnt <= drain_cnt + DW'(1);
            if (clear)
                txcount <= '0;
            else if (pop)
                txcount <= txcount + 32'd1;
`ifndef SYNTHESIS
            if (pop)
                $write("%c", head);
`endif
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            mem[wptr] <= print_wdata[7:0];
    end

endmodule

// File: tb/tb_print.sv
// tb_print: two print instances (fast and slow drain) against a
// queue-based reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_print;
    localparam int DEPTH = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        valid [2];
    logic        instr [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];

    logic [31:0] rdata_f;
    logic [31:0] rdata_s;
    logic        ready_f;
    logic        ready_s;

    logic [31:0] rd_a   [2];
    logic        rdy_a  [2];
    logic        pop_a  [2];
    logic [7:0]  head_a [2];

    print #(.FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(1)) u_fast (
        .clock(clock), .reset(reset),
        .print_valid(valid[0]), .print_instr(instr[0]),
        .print_addr(addr[0]), .print_wdata(wdata[0]),
        .print_wstrb(wstrb[0]), .print_rdata(rdata_f),
        .print_ready(ready_f)
    );

    print #(.FIFO_DEPTH(DEPTH), .DRAIN_CYCLES(100)) u_slow (
        .clock(clock), .reset(reset),
        .print_valid(valid[1]), .print_instr(instr[1]),
        .print_addr(addr[1]), .print_wdata(wdata[1]),
        .print_wstrb(wstrb[1]), .print_rdata(rdata_s),
        .print_ready(ready_s)
    );

    always_comb begin
        rd_a[0]   = rdata_f;
        rd_a[1]   = rdata_s;
        rdy_a[0]  = ready_f;
        rdy_a[1]  = ready_s;
        pop_a[0]  = u_fast.pop;
        pop_a[1]  = u_slow.pop;
        head_a[0] = u_fast.head;
        head_a[1] = u_slow.head;
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_s(string name, string act, string exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
        end
    endtask

    function automatic int dc(int i);
        return (i == 0) ? 1 : 100;
    endfunction

    // Reference model: a byte queue per instance and the edge of its next pop.
    logic [7:0]  mq [2][$];
    int          next_pop [2];
    logic [31:0] m_tx [2];
    logic        m_ready [2];
    logic [31:0] m_rdata [2];
    string       outs [2];
    int          cyc = 0;

    function automatic logic [31:0] status_of(int occ);
        logic [31:0] v;
        v = '0;
        v[0] = (occ == 0);
        v[1] = (occ == DEPTH);
        v[7:4] = (occ > 15) ? 4'hF : 4'(occ);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mq[i].delete();
            next_pop[i] = 0;
            m_tx[i] = '0;
            m_ready[i] = 1'b0;
            m_rdata[i] = '0;
        end
    endtask

    task automatic model_step(int i);
        int occ;
        logic do_pop;
        logic is_push;
        logic acc;
        logic clr;
        logic [31:0] val;
        logic [1:0] off;
        occ = mq[i].size();
        off = addr[i][3:2];
        do_pop = occ > 0 && cyc == next_pop[i];
        is_push = !instr[i] && off == 2'd0 && wstrb[i][0];
        clr = !instr[i] && off == 2'd2 && wstrb[i] != 4'd0;
        acc = valid[i] && !m_ready[i] && !(is_push && occ == DEPTH && !do_pop);
        val = '0;
        if (!instr[i] && off == 2'd1) val = status_of(occ);
        if (!instr[i] && off == 2'd2) val = m_tx[i];
        m_ready[i] = acc;
        m_rdata[i] = acc ? val : '0;
        if (do_pop) begin
            void'(mq[i].pop_front());
            m_tx[i] = m_tx[i] + 32'd1;
        end
        if (acc && is_push) mq[i].push_back(wdata[i][7:0]);
        if (acc && clr) m_tx[i] = '0;
        if (mq[i].size() > 0 && (do_pop || occ == 0))
            next_pop[i] = cyc + dc(i);
    endtask

    always begin
        @(posedge clock);
        cyc++;
        if (reset) begin
            for (int i = 0; i < 2; i++) model_step(i);
        end else begin
            model_reset();
        end
        @(negedge clock);
        if (!reset) model_reset();
        for (int i = 0; i < 2; i++) begin
            logic exp_pop;
            exp_pop = reset && mq[i].size() > 0 && next_pop[i] == cyc + 1;
            chk($sformatf("ready%0d", i), {31'd0, rdy_a[i]}, {31'd0, m_ready[i]});
            chk($sformatf("rdata%0d", i), rd_a[i], m_rdata[i]);
            chk($sformatf("pop%0d", i), {31'd0, pop_a[i]}, {31'd0, exp_pop});
            if (pop_a[i]) begin
                outs[i] = $sformatf("%s%c", outs[i], head_a[i]);
                if (mq[i].size() > 0)
                    chk($sformatf("head%0d", i), {24'd0, head_a[i]}, {24'd0, mq[i][0]});
            end
        end
    end

    task automatic access(input int i, input logic ins, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] ws,
                          output logic [31:0] rd, output int waited);
        logic got;
        @(posedge clock);
        #2;
        instr[i] = ins;
        addr[i]  = a;
        wdata[i] = wd;
        wstrb[i] = ws;
        valid[i] = 1'b1;
        waited = 0;
        got = 1'b0;
        rd = '0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clock);
            if (rdy_a[i]) begin
                got = 1'b1;
                break;
            end
            waited++;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL handshake_timeout inst %0d addr %h", i, a);
        end
        rd = rd_a[i];
        @(posedge clock);
        #2;
        valid[i] = 1'b0;
        instr[i] = 1'b0;
        wstrb[i] = '0;
        addr[i]  = '0;
        wdata[i] = '0;
    endtask

    task automatic write_reg(input int i, input logic [31:0] a,
                             input logic [31:0] d);
        logic [31:0] rd;
        int w;
        access(i, 1'b0, a, d, 4'b0001, rd, w);
    endtask

    task automatic read_reg(input int i, input logic [31:0] a,
                            output logic [31:0] v);
        int w;
        access(i, 1'b0, a, '0, 4'b0000, v, w);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        int w;
        string hello;
        hello = "HELLO";
        for (int i = 0; i < 2; i++) begin
            valid[i] = 1'b0;
            instr[i] = 1'b0;
            addr[i]  = '0;
            wdata[i] = '0;
            wstrb[i] = '0;
            outs[i]  = "";
        end
        model_reset();
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;

        read_reg(0, 32'h4, v);
        chk("status_after_reset", v, 32'h1);
        read_reg(0, 32'h8, v);
        chk("txcount_after_reset", v, 32'h0);

        access(0, 1'b0, 32'h0, 32'h41, 4'b0001, v, w);
        chk("txdata_latency", w, 1);
        chk("txdata_write_rdata", v, 32'h0);
        idle(4);
        chk_s("emit_A", outs[0], "A");
        read_reg(0, 32'h8, v);
        chk("txcount_after_A", v, 32'h1);

        read_reg(0, 32'h0, v);
        chk("txdata_read", v, 32'h0);
        read_reg(0, 32'hC, v);
        chk("reserved_read", v, 32'h0);
        access(0, 1'b0, 32'hC, 32'hFFFF_FFFF, 4'hF, v, w);
        access(0, 1'b0, 32'h0, 32'h42, 4'b0010, v, w);
        access(0, 1'b0, 32'h4, 32'hFFFF_FFFF, 4'hF, v, w);
        idle(4);
        chk_s("ignored_writes_no_emit", outs[0], "A");
        read_reg(0, 32'h8, v);
        chk("txcount_after_ignored", v, 32'h1);

        write_reg(0, 32'h8, 32'h0);
        read_reg(0, 32'h8, v);
        chk("txcount_cleared", v, 32'h0);
        for (int k = 0; k < 5; k++)
            write_reg(0, 32'h0, {24'd0, hello[k]});
        idle(6);
        chk_s("emit_HELLO", outs[0], "AHELLO");
        read_reg(0, 32'h4, v);
        chk("status_after_hello", v, 32'h1);
        read_reg(0, 32'h8, v);
        chk("txcount_after_hello", v, 32'h5);

        access(0, 1'b1, 32'h0, 32'h5A, 4'hF, v, w);
        chk("fetch_rdata", v, 32'h0);
        access(0, 1'b1, 32'h8, 32'h0, 4'hF, v, w);
        idle(4);
        chk_s("fetch_no_emit", outs[0], "AHELLO");
        read_reg(0, 32'h8, v);
        chk("txcount_after_fetch", v, 32'h5);

        for (int k = 0; k < 8; k++)
            write_reg(1, 32'h0, 32'h31 + k);
        read_reg(1, 32'h4, v);
        chk("status_full", v, 32'h82);
        access(1, 1'b0, 32'h0, 32'h39, 4'b0001, v, w);
        chk("ninth_push_stalled", {31'd0, w > 50}, 32'h1);
        idle(900);
        chk_s("emit_slow", outs[1], "123456789");
        read_reg(1, 32'h4, v);
        chk("status_slow_drained", v, 32'h1);
        read_reg(1, 32'h8, v);
        chk("txcount_slow", v, 32'h9);

        write_reg(1, 32'h0, 32'h5A);
        repeat (97) @(posedge clock);
        write_reg(1, 32'h8, 32'h0);
        read_reg(1, 32'h8, v);
        chk("clear_beats_increment", v, 32'h0);
        chk_s("emit_Z", outs[1], "123456789Z");

        for (int k = 0; k < 3; k++)
            write_reg(1, 32'h0, 32'h61 + k);
        @(posedge clock);
        #2;
        addr[1]  = 32'h4;
        valid[1] = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("ready_low_in_reset", {31'd0, rdy_a[1]}, 32'h0);
        chk("rdata_low_in_reset", rd_a[1], 32'h0);
        valid[1] = 1'b0;
        addr[1]  = '0;
        idle(3);
        reset = 1'b1;
        idle(300);
        read_reg(1, 32'h4, v);
        chk("status_after_midreset", v, 32'h1);
        chk_s("no_emit_after_reset", outs[1], "123456789Z");
        read_reg(0, 32'h4, v);
        chk("fast_status_after_reset", v, 32'h1);

        $display("");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
